// File: rtl/photoncore_pkg.sv
// Shared opcodes, timeout pattern and frame FSM encoding for the SPI frame receiver.
package photoncore_pkg;

  localparam logic [7:0] OP_WR_PHASE  = 8'h01;
  localparam logic [7:0] OP_RD_ADC    = 8'h02;
  localparam logic [7:0] OP_WR_CAL    = 8'h03;
  localparam logic [7:0] OP_START_FWD = 8'h04;
  localparam logic [7:0] OP_START_CAL = 8'h05;
  localparam logic [7:0] OP_CLR_ERR   = 8'h06;

  localparam logic [15:0] RD_TIMEOUT_PATTERN = 16'hDEAD;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_WDATA  = 3'd3;
  localparam state_t ST_RDUMMY = 3'd4;
  localparam state_t ST_RDATA  = 3'd5;
  localparam state_t ST_DRAIN  = 3'd6;

endpackage

// File: rtl/photoncore_tgl_sync.sv
// Multi-flop synchroniser bringing the core-domain ack toggle into spi_clk.
module photoncore_tgl_sync #(
  parameter int STAGES = 2
) (
  input  logic spi_clk,
  input  logic sys_rst,
  input  logic tgl_i,
  output logic tgl_o
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain; STAGES must be at least 2.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], tgl_i};
  end

  assign tgl_o = sync_q[STAGES-1];

endmodule

// File: rtl/photoncore_spi_frame_rx.sv
// SPI mode-0 slave: frames opcode/address/data, hands requests to the core via toggle handshake.
module photoncore_spi_frame_rx
  import photoncore_pkg::*;
#(
  parameter int ADDR_BITS   = 24,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 spi_clk,
  input  logic                 sys_rst,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 req_tgl,
  input  logic                 ack_tgl,
  output logic [7:0]           cmd_code,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic [DATA_BITS-1:0] cmd_wdata,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 frame_err,
  output logic                 ovf_err
);

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BITS / 8 - 1);
  localparam logic [1:0] RD_LAST   = 2'(DATA_BITS / 8 - 1);

  state_t               state_q, state_d;
  logic [2:0]           bit_cnt_q;
  logic [1:0]           byte_cnt_q;
  logic [6:0]           rx_sh_q;
  logic [7:0]           op_q, hi_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 req_tgl_q, ferr_q, ovf_q, rd_pend_q, miso_q;
  logic [7:0]           cmd_code_q;
  logic [ADDR_BITS-1:0] cmd_addr_q;
  logic [DATA_BITS-1:0] cmd_wdata_q, tx_q;

  logic                 ack_s, busy, byte_done, word_done;
  logic [7:0]           rx_byte;
  logic                 req_fire, set_ferr, clr_err, load_rd, load_dead;
  logic [7:0]           req_code;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;

  photoncore_tgl_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .spi_clk (spi_clk),
    .sys_rst (sys_rst),
    .tgl_i   (ack_tgl),
    .tgl_o   (ack_s)
  );

  // A cs_n-high edge never completes a byte, which gives aborts priority over word issue.
  assign byte_done = !spi_cs_n && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_sh_q, spi_mosi};
  assign busy      = req_tgl_q != ack_s;
  assign word_done = (state_q == ST_WDATA) && byte_done && byte_cnt_q[0];

  // State register.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: frame phase sequencing, cs_n high always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (spi_cs_n) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE, ST_CMD: begin
          state_d = ST_CMD;
          if (byte_done) begin
            if (rx_byte == OP_WR_PHASE || rx_byte == OP_WR_CAL || rx_byte == OP_RD_ADC)
              state_d = ST_ADDR;
            else
              state_d = ST_DRAIN;
          end
        end
        ST_ADDR:   if (byte_done && byte_cnt_q == ADDR_LAST)
                     state_d = (op_q == OP_RD_ADC) ? ST_RDUMMY : ST_WDATA;
        ST_RDUMMY: if (byte_done) state_d = ST_RDATA;
        ST_RDATA:  if (byte_done && byte_cnt_q == RD_LAST) state_d = ST_DRAIN;
        default:   state_d = state_q;
      endcase
    end
  end

  // Output strobes: request issue, error set/clear, read-data load.
  always_comb begin
    req_fire  = 1'b0;
    req_code  = op_q;
    req_addr  = addr_q;
    req_wdata = '0;
    set_ferr  = 1'b0;
    clr_err   = 1'b0;
    load_rd   = 1'b0;
    load_dead = 1'b0;
    if (!spi_cs_n) begin
      case (state_q)
        ST_IDLE, ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              OP_START_FWD, OP_START_CAL: begin
                req_fire = 1'b1;
                req_code = rx_byte;
                req_addr = '0;
              end
              OP_CLR_ERR: clr_err = 1'b1;
              OP_WR_PHASE, OP_WR_CAL, OP_RD_ADC: ;
              default: set_ferr = 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done && byte_cnt_q == ADDR_LAST && op_q == OP_RD_ADC) begin
            req_fire = 1'b1;
            req_addr = {addr_q[ADDR_BITS-9:0], rx_byte};
          end
        end
        ST_WDATA: begin
          if (word_done) begin
            req_fire  = 1'b1;
            req_wdata = {hi_q, rx_byte};
          end
        end
        ST_RDUMMY: begin
          if (rd_pend_q && !busy) load_rd = 1'b1;
          else if (rd_pend_q && byte_done) begin
            load_dead = 1'b1;
            set_ferr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bit/byte counters and the receive shifter; cs_n high discards partial bytes.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_sh_q    <= '0;
    end else if (spi_cs_n) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_sh_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_sh_q   <= {rx_sh_q[5:0], spi_mosi};
      if (byte_done) byte_cnt_q <= (state_d != state_q) ? 2'd0 : byte_cnt_q + 2'd1;
    end
  end

  // Frame fields: opcode, base/running address (wraps naturally), data high byte.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      op_q   <= '0;
      hi_q   <= '0;
      addr_q <= '0;
    end else if (!spi_cs_n && byte_done) begin
      if (state_q == ST_IDLE || state_q == ST_CMD) op_q <= rx_byte;
      if (state_q == ST_ADDR) addr_q <= {addr_q[ADDR_BITS-9:0], rx_byte};
      if (state_q == ST_WDATA && !byte_cnt_q[0]) hi_q <= rx_byte;
      if (word_done) addr_q <= addr_q + 1'b1;
    end
  end

  // Request register, sticky errors and the outstanding-read flag.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      req_tgl_q   <= 1'b0;
      cmd_code_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      if (req_fire && !busy) begin
        req_tgl_q   <= ~req_tgl_q;
        cmd_code_q  <= req_code;
        cmd_addr_q  <= req_addr;
        cmd_wdata_q <= req_wdata;
      end
      if (clr_err) begin
        ferr_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (set_ferr)         ferr_q <= 1'b1;
        if (req_fire && busy) ovf_q  <= 1'b1;
      end
      if (spi_cs_n)                             rd_pend_q <= 1'b0;
      else if (req_fire && state_q == ST_ADDR)  rd_pend_q <= 1'b1;
      else if (load_rd || load_dead)            rd_pend_q <= 1'b0;
    end
  end

  // Transmit shifter: load read result (or timeout pattern), shift once per RDATA bit.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst)                               tx_q <= '0;
    else if (load_rd)                          tx_q <= rd_data;
    else if (load_dead)                        tx_q <= RD_TIMEOUT_PATTERN;
    else if (!spi_cs_n && state_q == ST_RDATA) tx_q <= {tx_q[DATA_BITS-2:0], 1'b0};
  end

  // MISO launches on the falling edge so the host samples it on the next rising edge.
  always_ff @(negedge spi_clk or posedge sys_rst) begin
    if (sys_rst) miso_q <= 1'b0;
    else         miso_q <= (state_q == ST_RDATA) ? tx_q[DATA_BITS-1] : 1'b0;
  end

  assign spi_miso  = miso_q;
  assign req_tgl   = req_tgl_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign frame_err = ferr_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_photoncore_spi_frame_rx.sv
// Directed bench: SPI host driver, simple core ack model, request log and hand-computed expectations.
module tb_photoncore_spi_frame_rx;

  logic        spi_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        req_tgl;
  logic        ack_tgl = 1'b0;
  logic [7:0]  cmd_code;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rd_data = 16'h3A5C;
  logic        frame_err, ovf_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  c;
    logic [23:0] a;
    logic [15:0] w;
  } req_t;
  req_t rq[$];

  logic       ack_en = 1'b1;
  int         ack_cnt = 0;
  logic       prev_req = 1'b0;
  logic [7:0] fr [8];
  logic [7:0] mo [8];

  photoncore_spi_frame_rx dut (
    .spi_clk   (spi_clk),
    .sys_rst   (sys_rst),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .req_tgl   (req_tgl),
    .ack_tgl   (ack_tgl),
    .cmd_code  (cmd_code),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rd_data   (rd_data),
    .frame_err (frame_err),
    .ovf_err   (ovf_err)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Core model: acknowledges a pending request 4 clocks after it appears.
  initial forever begin
    @(negedge spi_clk);
    if (sys_rst) begin
      ack_tgl = 1'b0;
      ack_cnt = 0;
    end else if (ack_en && req_tgl != ack_tgl) begin
      ack_cnt++;
      if (ack_cnt >= 4) begin
        ack_tgl = req_tgl;
        ack_cnt = 0;
      end
    end else ack_cnt = 0;
  end

  // Request log: every req_tgl flip records the command fields.
  initial forever begin
    @(negedge spi_clk);
    #1;
    if (sys_rst) prev_req = 1'b0;
    else if (req_tgl != prev_req) begin
      prev_req = req_tgl;
      rq.push_back('{c: cmd_code, a: cmd_addr, w: cmd_wdata});
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] mb);
    mb = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge spi_clk);
      spi_cs_n = 1'b0;
      spi_mosi = b[7-i];
      #2 mb[7-i] = spi_miso;
    end
  endtask

  task automatic cs_high(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge spi_clk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
    end
  endtask

  task automatic send_frame(input int n);
    logic [7:0] m;
    for (int i = 0; i < n; i++) begin
      send_bits(fr[i], 8, m);
      mo[i] = m;
    end
    cs_high(12);
  endtask

  task automatic chk_req(input string tag, input logic [7:0] c, input logic [23:0] a, input logic [15:0] w);
    req_t r;
    r = '0;
    if (rq.size() > 0) r = rq.pop_front();
    check({tag, "_code"}, r.c, c);
    check({tag, "_addr"}, r.a, a);
    check({tag, "_wdata"}, r.w, w);
  endtask

  initial begin
    repeat (3) @(negedge spi_clk);
    #1;
    check("rst_req_tgl", req_tgl, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_wdata", cmd_wdata, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_miso", spi_miso, 0);
    @(negedge spi_clk);
    sys_rst = 1'b0;
    cs_high(4);

    // Write phase, two words.
    fr = '{8'h01, 8'h00, 8'h00, 8'h10, 8'hAB, 8'hCD, 8'h12, 8'h34};
    send_frame(8);
    check("wr_nreq", rq.size(), 2);
    chk_req("wr_r0", 8'h01, 24'h000010, 16'hABCD);
    chk_req("wr_r1", 8'h01, 24'h000011, 16'h1234);
    check("wr_ferr", frame_err, 0);
    check("wr_ovf", ovf_err, 0);

    // Write cal with address wrap.
    fr = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02};
    send_frame(8);
    check("wrap_nreq", rq.size(), 2);
    chk_req("wrap_r0", 8'h03, 24'hFFFFFF, 16'h0001);
    chk_req("wrap_r1", 8'h03, 24'h000000, 16'h0002);

    // ADC read, ack in time.
    fr = '{8'h02, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(7);
    check("rd_nreq", rq.size(), 1);
    chk_req("rd_r0", 8'h02, 24'h000005, 16'h0000);
    check("rd_dummy", mo[4], 8'h00);
    check("rd_hi", mo[5], 8'h3A);
    check("rd_lo", mo[6], 8'h5C);
    check("rd_ferr", frame_err, 0);

    // ADC read, ack withheld -> timeout pattern.
    ack_en = 1'b0;
    send_frame(7);
    check("to_hi", mo[5], 8'hDE);
    check("to_lo", mo[6], 8'hAD);
    check("to_ferr", frame_err, 1);
    check("to_nreq", rq.size(), 1);
    rq.delete();
    ack_en = 1'b1;
    cs_high(12);
    fr[0] = 8'h06;
    send_frame(1);
    check("clr1_ferr", frame_err, 0);
    check("clr1_nreq", rq.size(), 0);

    // Overflow: second word dropped while first unacked.
    ack_en = 1'b0;
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
    send_frame(8);
    check("ovf_nreq", rq.size(), 1);
    chk_req("ovf_r0", 8'h01, 24'h000000, 16'h1111);
    check("ovf_wdata_kept", cmd_wdata, 16'h1111);
    check("ovf_flag", ovf_err, 1);
    check("ovf_ferr", frame_err, 0);
    ack_en = 1'b1;
    cs_high(12);
    fr[0] = 8'h06;
    send_frame(1);
    check("clr2_ovf", ovf_err, 0);
    check("clr2_ferr", frame_err, 0);

    // Abort mid-word: no request, then a normal start command.
    begin
      logic [7:0] m;
      send_bits(8'h01, 8, m);
      send_bits(8'h00, 8, m);
      send_bits(8'h00, 8, m);
      send_bits(8'h00, 8, m);
      send_bits(8'hAB, 8, m);
      send_bits(8'hCD, 4, m);
      cs_high(12);
    end
    check("abort_nreq", rq.size(), 0);
    fr[0] = 8'h04;
    send_frame(1);
    check("fwd_nreq", rq.size(), 1);
    chk_req("fwd_r0", 8'h04, 24'h000000, 16'h0000);

    // Bad opcode.
    fr = '{8'h7F, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    check("bad_ferr", frame_err, 1);
    check("bad_nreq", rq.size(), 0);
    check("bad_req_tgl", req_tgl, 0);

    // Outstanding request, then reset mid-frame.
    ack_en = 1'b0;
    fr[0] = 8'h05;
    send_frame(1);
    check("pre_rst_req_tgl", req_tgl, 1);
    check("pre_rst_code", cmd_code, 8'h05);
    begin
      logic [7:0] m;
      send_bits(8'h01, 8, m);
      send_bits(8'h00, 5, m);
    end
    #3 sys_rst = 1'b1;
    #1;
    check("mid_rst_req_tgl", req_tgl, 0);
    check("mid_rst_code", cmd_code, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovf", ovf_err, 0);
    check("mid_rst_miso", spi_miso, 0);
    cs_high(3);
    sys_rst = 1'b0;
    cs_high(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
